reg_file: RTL and testbench

- 32 x 32-bit integer register file for the single-cycle RV32I datapath.
- Sits directly upstream of the ALU-source 2:1 mux: read port 2 (rd_data2) feeds the mux's register-operand input; the mux's other input is the immediate.
- Two combinational read ports and one synchronous write port. x0 is hardwired to zero.

---
 rtl/riscv_pkg.sv | 13 +
 rtl/rf_read_port.sv | 44 ++++
 rtl/reg_file.sv | 66 ++++++
 tb/tb_reg_file.sv | 185 ++++++++++++++++++
 4 files changed

// File: rtl/riscv_pkg.sv
// Shared RV32I datapath definitions: operand width, register index width,
// the index and data word types, and the hardwired-zero register index.
package riscv_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;

  typedef logic [REG_ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]       word_t;

  localparam reg_idx_t ZERO_REG = 5'd0;

endpackage : riscv_pkg

// File: rtl/rf_read_port.sv
// One combinational register-file read port: x0 reads as zero, otherwise the
// stored entry is returned. When REGFILE_BYPASS_EN is defined, a write
// presented in the same cycle to the same index is forwarded (write-first),
// except while reset is asserted.
module rf_read_port
  import riscv_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] stored_data,
  output logic [DATA_W-1:0] rd_data
);

`ifdef REGFILE_BYPASS_EN
  // Zero-check first, then forward a same-cycle write, else stored contents.
  always_comb begin
    rd_data = stored_data;
    if (rd_addr == ZERO_REG) begin
      rd_data = '0;
    end else if (we && !rst && (wr_addr == rd_addr)) begin
      rd_data = wr_data;
    end
  end
`else
  // Without forwarding the write-side inputs have no effect on the read.
  logic unused_write_side;
  assign unused_write_side = &{1'b0, rst, we, wr_addr, wr_data};

  // Zero-check, else stored contents (old value during a same-cycle write).
  always_comb begin
    rd_data = stored_data;
    if (rd_addr == ZERO_REG) begin
      rd_data = '0;
    end
  end
`endif

endmodule : rf_read_port

// File: rtl/reg_file.sv
// 32 x 32-bit RV32I integer register file: two combinational read ports and
// one synchronous write port; x0 is hardwired to zero. Read port 2 feeds the
// register-operand input of the ALU-source mux.
// Optional macro REGFILE_BYPASS_EN enables write-first forwarding on reads.
module reg_file
  import riscv_pkg::*;
#(
  parameter int DATA_W = XLEN,
  parameter int ADDR_W = REG_ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic [ADDR_W-1:0] rd_addr1,
  input  logic [ADDR_W-1:0] rd_addr2,
  output logic [DATA_W-1:0] rd_data1,
  output logic [DATA_W-1:0] rd_data2
);

  localparam int DEPTH = 2 ** ADDR_W;

  // Flop-based storage: the whole array must clear in one reset cycle and
  // both reads are asynchronous, so this cannot map onto block RAM.
  logic [DATA_W-1:0] entry_reg [DEPTH];

  // Reset clears every entry and wins over a write; x0 is never written.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entry_reg[i] <= '0;
      end
    end else if (we && (wr_addr != ZERO_REG)) begin
      entry_reg[wr_addr] <= wr_data;
    end
  end

  // Both read ports share one helper; gather them into arrays for the loop.
  logic [ADDR_W-1:0] rd_addr_arr [2];
  logic [DATA_W-1:0] rd_data_arr [2];

  assign rd_addr_arr[0] = rd_addr1;
  assign rd_addr_arr[1] = rd_addr2;
  assign rd_data1       = rd_data_arr[0];
  assign rd_data2       = rd_data_arr[1];

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_read_port
      rf_read_port #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W)
      ) u_read_port (
        .rst         (rst),
        .we          (we),
        .wr_addr     (wr_addr),
        .wr_data     (wr_data),
        .rd_addr     (rd_addr_arr[gi]),
        .stored_data (entry_reg[rd_addr_arr[gi]]),
        .rd_data     (rd_data_arr[gi])
      );
    end
  endgenerate

endmodule : reg_file

// File: tb/tb_reg_file.sv
// Directed self-checking bench for reg_file. Inputs change 1 time unit after
// a rising edge; outputs are sampled 1 further unit later, mid-cycle.
// Expected read-during-write values depend on REGFILE_BYPASS_EN.
`timescale 1ns/1ps
module tb_reg_file;

  logic        clk;
  logic        rst;
  logic        we;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;
  logic [4:0]  rd_addr1;
  logic [4:0]  rd_addr2;
  logic [31:0] rd_data1;
  logic [31:0] rd_data2;

  int vec_cnt;
  int miscompare_cnt;

  reg_file dut (
    .clk      (clk),
    .rst      (rst),
    .we       (we),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data),
    .rd_addr1 (rd_addr1),
    .rd_addr2 (rd_addr2),
    .rd_data1 (rd_data1),
    .rd_data2 (rd_data2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      miscompare_cnt++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end else begin
      $display("ok   %s: 0x%08h", tag, got);
    end
  endtask

  // Advance past the next rising edge; inputs may then be changed safely.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Let combinational reads settle before sampling.
  task automatic settle();
    #1;
  endtask

  task automatic write_reg(input logic [4:0] a, input logic [31:0] d);
    we      = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    we      = 1'b0;
  endtask

  function automatic logic [31:0] sweep_pat(input int i);
    logic [31:0] v;
    v = 32'(i) * 32'h0101_0101;
    return (i == 0) ? 32'h0 : v;
  endfunction

  logic [31:0] rdw_exp;

  initial begin
    vec_cnt        = 0;
    miscompare_cnt = 0;
    rst      = 1'b1;
    we       = 1'b0;
    wr_addr  = '0;
    wr_data  = '0;
    rd_addr1 = '0;
    rd_addr2 = '0;

    // Reset state
    tick();
    rst      = 1'b0;
    rd_addr1 = 5'd5;
    rd_addr2 = 5'd31;
    settle();
    check("reset_x5_p1", rd_data1, 32'h0);
    check("reset_x31_p2", rd_data2, 32'h0);

    // Reset clears a written register
    write_reg(5'd5, 32'hDEAD_BEEF);
    settle();
    check("x5_written", rd_data1, 32'hDEAD_BEEF);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    settle();
    check("x5_after_reset", rd_data1, 32'h0);

    // Basic write/read on both ports
    write_reg(5'd7, 32'h1234_5678);
    rd_addr1 = 5'd7;
    rd_addr2 = 5'd7;
    settle();
    check("x7_p1", rd_data1, 32'h1234_5678);
    check("x7_p2", rd_data2, 32'h1234_5678);

    // we=0 leaves the array unchanged
    wr_addr = 5'd7;
    wr_data = 32'hCAFE_F00D;
    tick();
    settle();
    check("x7_we0_hold", rd_data1, 32'h1234_5678);

    // x0 protection
    write_reg(5'd0, 32'hFFFF_FFFF);
    rd_addr1 = 5'd0;
    rd_addr2 = 5'd0;
    settle();
    check("x0_p1", rd_data1, 32'h0);
    check("x0_p2", rd_data2, 32'h0);

    // Read during write to x3
    write_reg(5'd3, 32'h0000_0011);
    rd_addr1 = 5'd3;
    rd_addr2 = 5'd3;
    we       = 1'b1;
    wr_addr  = 5'd3;
    wr_data  = 32'h0000_0022;
    settle();
`ifdef REGFILE_BYPASS_EN
    rdw_exp = 32'h0000_0022;
`else
    rdw_exp = 32'h0000_0011;
`endif
    check("rdw_same_cycle_p2", rd_data2, rdw_exp);
    check("rdw_same_cycle_p1", rd_data1, rdw_exp);
    tick();
    we = 1'b0;
    settle();
    check("rdw_after_edge_p2", rd_data2, 32'h0000_0022);

    // Writing x0 with a matching read still returns zero
    rd_addr2 = 5'd0;
    we       = 1'b1;
    wr_addr  = 5'd0;
    wr_data  = 32'h5A5A_5A5A;
    settle();
    check("x0_write_read_same_cycle", rd_data2, 32'h0);
    tick();
    we = 1'b0;

    // Reset beats a simultaneous write; no forwarding while in reset
    write_reg(5'd9, 32'h0000_5555);
    rd_addr2 = 5'd9;
    rst      = 1'b1;
    we       = 1'b1;
    wr_addr  = 5'd9;
    wr_data  = 32'h0000_ABCD;
    settle();
    check("x9_during_rst_write", rd_data2, 32'h0000_5555);
    tick();
    rst = 1'b0;
    we  = 1'b0;
    settle();
    check("x9_rst_priority", rd_data2, 32'h0);

    // Sweep: fill x1..x31, then read pairs (i, 31-i)
    for (int i = 1; i < 32; i++) begin
      write_reg(5'(i), sweep_pat(i));
    end
    for (int i = 0; i < 32; i++) begin
      rd_addr1 = 5'(i);
      rd_addr2 = 5'(31 - i);
      settle();
      check($sformatf("sweep_p1_x%0d", i), rd_data1, sweep_pat(i));
      check($sformatf("sweep_p2_x%0d", 31 - i), rd_data2, sweep_pat(31 - i));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, miscompare_cnt);
    $finish;
  end

endmodule : tb_reg_file
